// File: rtl/clint_mh.sv
// ============================================================================
// Module   : clint_mh
// Purpose  : Multi-hart CLINT with a shared 64-bit mtime and per-hart
//            msip/mtimecmp. An ICB slave with a programmable tick prescaler.
//            Optional macro: MYRISCV_CLINT_MTIME_SNAP_EN (tear-free mtime read)
// Revision : 1.0
// ============================================================================
`default_nettype none

module clint_mh #(
  parameter int NHART    = 2,
  parameter int TICK_DIV = 1,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timer_en,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [AW-1:0]     icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [DW/8-1:0]   icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic [NHART-1:0]  soft_irq_o,
  output logic [NHART-1:0]  tmr_irq_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  wm);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (wm[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [15:0]      off;
  logic             hit_msip, hit_cmp, hit_mtlo, hit_mthi, hit;
  logic             accept, wr, rd, tick;
  logic [63:0]      mtime_q, mtime_d;
  logic [NHART-1:0] msip_q, tmr_q;
  logic [63:0]      mtimecmp_q [NHART];
  logic [31:0]      rdata_mux;
  logic             rsp_valid_q, rsp_err_q;
  logic [31:0]      rsp_rdata_q;
  logic             unused_ok;

  assign off       = icb_cmd_addr[15:0];
  assign unused_ok = ^{icb_cmd_addr};

  assign hit_msip = (off[15:6] == 10'd0) && (off[1:0] == 2'd0) &&
                    ({1'b0, off[5:2]} < 5'(NHART));
  assign hit_cmp  = (off[15:7] == 9'h080) && (off[1:0] == 2'd0) &&
                    ({1'b0, off[6:3]} < 5'(NHART));
  assign hit_mtlo = (off == 16'hBFF8);
  assign hit_mthi = (off == 16'hBFFC);
  assign hit      = hit_msip | hit_cmp | hit_mtlo | hit_mthi;

  assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
  assign accept        = icb_cmd_valid & icb_cmd_ready;
  assign wr            = accept & ~icb_cmd_read;
  assign rd            = accept & icb_cmd_read;

  generate
    if (TICK_DIV == 1) begin : g_nodiv
      assign tick = timer_en;
    end else begin : g_div
      logic [PW-1:0] pcnt_q, pcnt_d;
      logic          wrap;
      assign wrap = timer_en && (pcnt_q == PW'(TICK_DIV - 1));
      assign tick = wrap;
      always_comb begin
        pcnt_d = pcnt_q;
        if (wrap)          pcnt_d = '0;
        else if (timer_en) pcnt_d = pcnt_q + PW'(1);
      end
      always_ff @(posedge clk) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
      end
    end
  endgenerate

  // A bus write to either half wins over the tick in the same cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && hit_mtlo)
      mtime_d[31:0] = merge(mtime_q[31:0], icb_cmd_wdata, icb_cmd_wmask);
    else if (wr && hit_mthi)
      mtime_d[63:32] = merge(mtime_q[63:32], icb_cmd_wdata, icb_cmd_wmask);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) mtime_q <= '0;
    else     mtime_q <= mtime_d;
  end

`ifdef MYRISCV_CLINT_MTIME_SNAP_EN
  logic [31:0] shadow_q;
  always_ff @(posedge clk) begin
    if (rst)
      shadow_q <= '0;
    else if (rd && hit_mtlo)
      shadow_q <= mtime_q[63:32];
    else if (wr && hit_mthi)
      shadow_q <= merge(mtime_q[63:32], icb_cmd_wdata, icb_cmd_wmask);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= '0;
      tmr_q  <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp_q[h] <= '1;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        tmr_q[h] <= (mtime_q >= mtimecmp_q[h]);
        if (wr && hit_msip && off[5:2] == 4'(h) && icb_cmd_wmask[0])
          msip_q[h] <= icb_cmd_wdata[0];
        if (wr && hit_cmp && off[6:3] == 4'(h)) begin
          if (off[2])
            mtimecmp_q[h][63:32] <= merge(mtimecmp_q[h][63:32], icb_cmd_wdata, icb_cmd_wmask);
          else
            mtimecmp_q[h][31:0]  <= merge(mtimecmp_q[h][31:0], icb_cmd_wdata, icb_cmd_wmask);
        end
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    for (int h = 0; h < NHART; h++) begin
      if (hit_msip && off[5:2] == 4'(h)) rdata_mux = {31'd0, msip_q[h]};
      if (hit_cmp && off[6:3] == 4'(h))
        rdata_mux = off[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
    end
    if (hit_mtlo) rdata_mux = mtime_q[31:0];
`ifdef MYRISCV_CLINT_MTIME_SNAP_EN
    if (hit_mthi) rdata_mux = shadow_q;
`else
    if (hit_mthi) rdata_mux = mtime_q[63:32];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= ~hit;
      rsp_rdata_q <= icb_cmd_read ? rdata_mux : 32'd0;
    end else if (icb_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_err   = rsp_err_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign soft_irq_o    = msip_q;
  assign tmr_irq_o     = tmr_q;

endmodule

`default_nettype wire

// File: tb/tb_clint_mh.sv
// ============================================================================
// Module   : tb_clint_mh
// Purpose  : Directed self-checking bench for clint_mh (NHART=2, TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clint_mh;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_en;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  soft_irq, tmr_irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] rdat;
  logic        rerr;

  always #5 clk = ~clk;

  clint_mh #(.NHART(2), .TICK_DIV(4), .AW(32), .DW(32)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .timer_en      (timer_en),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (cmd_ready),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_err   (rsp_err),
    .icb_rsp_rdata (rsp_rdata),
    .soft_irq_o    (soft_irq),
    .tmr_irq_o     (tmr_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that
  // makes the response visible.
  task automatic bus(input logic rd_i, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output logic [31:0] rd_o, output logic err_o);
    int n = 0;
    cmd_valid = 1'b1; cmd_read = rd_i; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rsp_valid_latency1", rsp_valid, 1'b1);
    rd_o  = rsp_rdata;
    err_o = rsp_err;
  endtask

  task automatic run_timer(input int cycles);
    timer_en = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 timer_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; timer_en = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_soft_irq",  soft_irq, 0);
    check("rst_tmr_irq",   tmr_irq, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    bus(1, 32'h4000, 0, 0, rdat, rerr);
    check("cmp0_lo_reset", rdat, 32'hFFFF_FFFF);
    check("cmp0_lo_err",   rerr, 0);

    bus(0, 32'h0004, 32'h1, 4'hF, rdat, rerr);
    check("msip1_set_irq", soft_irq, 2'b10);
    bus(1, 32'h0004, 0, 0, rdat, rerr);
    check("msip1_read", rdat, 32'h1);
    bus(0, 32'h0004, 32'h0, 4'hF, rdat, rerr);
    check("msip1_clr_irq", soft_irq, 2'b00);
    bus(0, 32'h0000, 32'hFFFF_FFFF, 4'h0, rdat, rerr);
    check("wmask0_err", rerr, 0);
    check("wmask0_noeffect", soft_irq, 2'b00);

    bus(0, 32'h4008, 32'hAABB_CCDD, 4'h5, rdat, rerr);
    bus(1, 32'h4008, 0, 0, rdat, rerr);
    check("cmp1_lo_bytemerge", rdat, 32'hFFBB_FFDD);

    // 12 enabled cycles at TICK_DIV=4 -> 3 ticks, prescaler back at 0
    run_timer(12);
    bus(1, 32'hBFF8, 0, 0, rdat, rerr);
    check("mtime_after_12", rdat, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus(1, 32'hBFF8, 0, 0, rdat, rerr);
    check("mtime_frozen", rdat, 32'd3);

    bus(0, 32'hBFFC, 32'h0, 4'hF, rdat, rerr);
    bus(0, 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rdat, rerr);
    bus(1, 32'hBFF8, 0, 0, rdat, rerr);
    check("mtime_lo_preset", rdat, 32'hFFFF_FFFF);
    run_timer(4);
    bus(1, 32'hBFF8, 0, 0, rdat, rerr);
    check("carry_lo", rdat, 32'h0);
    bus(1, 32'hBFFC, 0, 0, rdat, rerr);
    check("carry_hi", rdat, 32'h1);

    // lo read just before the carry, hi read after it
    bus(0, 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rdat, rerr);
    bus(0, 32'hBFFC, 32'h0, 4'hF, rdat, rerr);
    bus(1, 32'hBFF8, 0, 0, rdat, rerr);
    check("snap_lo", rdat, 32'hFFFF_FFFF);
    run_timer(4);
    bus(1, 32'hBFFC, 0, 0, rdat, rerr);
`ifdef MYRISCV_CLINT_MTIME_SNAP_EN
    check("snap_hi_shadow", rdat, 32'h0);
`else
    check("snap_hi_live", rdat, 32'h1);
`endif

    bus(0, 32'hBFFC, 32'h0, 4'hF, rdat, rerr);
    bus(0, 32'hBFF8, 32'hF, 4'hF, rdat, rerr);
    bus(0, 32'h4004, 32'h0, 4'hF, rdat, rerr);
    bus(0, 32'h4000, 32'h10, 4'hF, rdat, rerr);
    repeat (2) @(posedge clk);
    #1;
    check("tmr_below_cmp", tmr_irq, 2'b00);
    bus(0, 32'hBFF8, 32'h10, 4'hF, rdat, rerr);
    check("tmr_same_cycle", tmr_irq, 2'b00);
    @(posedge clk); #1;
    check("tmr_one_cycle_after", tmr_irq, 2'b01);

    bus(1, 32'h4010, 0, 0, rdat, rerr);
    check("unmap_4010_err",   rerr, 1);
    check("unmap_4010_rdata", rdat, 0);
    bus(1, 32'h8000, 0, 0, rdat, rerr);
    check("unmap_8000_err",   rerr, 1);
    check("unmap_8000_rdata", rdat, 0);
    bus(0, 32'h0008, 32'h1, 4'hF, rdat, rerr);
    check("unmap_msip2_werr", rerr, 1);
    check("unmap_msip2_noirq", soft_irq, 2'b00);
    bus(1, 32'h0002, 0, 0, rdat, rerr);
    check("unaligned_err", rerr, 1);

    rsp_ready = 1'b0;
    bus(1, 32'h8000, 0, 0, rdat, rerr);
    for (int i = 0; i < 3; i++) begin
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_err",   rsp_err, 1);
      check("stall_rsp_rdata", rsp_rdata, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", rsp_valid, 0);

    rsp_ready = 1'b0;
    bus(1, 32'h4000, 0, 0, rdat, rerr);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_tmr_irq",   tmr_irq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
